// File: rtl/fetch.sv
// Instruction fetch: one outstanding imem request, one-entry skid buffer, registered output to decode.
// Latency ack->instr_valid is 2 cycles; stall holds the output, parks one response in the buffer, then blocks issue.
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] req_pc_q;
  logic        buf_vld_q;
  logic [31:0] buf_dat_q;
  logic [31:0] buf_pc_q;

  logic        rsp;
  logic        out_load;
  logic        req_raw;
  logic        accept;

  assign rsp       = (state_q == S_WAIT) && imem_rvalid;
  assign out_load  = !instr_valid || !stall;
  assign imem_addr = pc_q;
  assign imem_req  = req_raw && rst_n;
  assign accept    = imem_req && imem_ack;

  always_comb begin
    req_raw = 1'b0;
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        req_raw = !buf_vld_q && !redirect;
        if (req_raw && imem_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (redirect) begin
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          // Back-to-back issue only when the response lands straight in the output register.
          req_raw = out_load;
          state_d = (req_raw && imem_ack) ? S_WAIT : S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (redirect) begin
        pc_q <= redirect_pc;
      end else if (accept) begin
        pc_q <= pc_q + 32'd4;
      end
      if (accept) req_pc_q <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
      buf_vld_q   <= 1'b0;
      buf_dat_q   <= 32'h0;
      buf_pc_q    <= 32'h0;
    end else if (redirect) begin
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      buf_vld_q   <= 1'b0;
    end else if (out_load) begin
      if (buf_vld_q) begin
        instr_valid <= 1'b1;
        instr       <= buf_dat_q;
        instr_pc    <= buf_pc_q;
        buf_vld_q   <= 1'b0;
      end else if (rsp) begin
        instr_valid <= 1'b1;
        instr       <= imem_rdata;
        instr_pc    <= req_pc_q;
      end else begin
        instr_valid <= 1'b0;
        instr       <= NOP_INSTR;
      end
    end else if (rsp) begin
      buf_vld_q <= 1'b1;
      buf_dat_q <= imem_rdata;
      buf_pc_q  <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Fetch bench: directed scenarios plus randomized stall/redirect/ack traffic against a program-order stream model.
module tb_fetch;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;

  int checks   = 0;
  int failures = 0;
  int consumed = 0;
  int ack_pct  = 100;
  int delay    = 1;

  fetch #(.RESET_PC(RPC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h0000_010A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory: random ack, response a fixed number of cycles after acceptance.
  logic        acc;
  logic [31:0] acc_addr;
  logic [31:0] pend_addr;
  bit          pend;
  int          cnt;

  initial begin
    imem_ack    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend        = 1'b0;
    cnt         = 0;
    forever begin
      @(negedge clk); #4;
      acc      = rst_n && imem_req && imem_ack;
      acc_addr = imem_addr;
      if (!rst_n) pend = 1'b0;
      if (acc) chk("one_outstanding", {31'h0, pend}, 32'h0);
      @(posedge clk); #1;
      if (acc) begin
        pend      = 1'b1;
        cnt       = delay;
        pend_addr = acc_addr;
      end
      imem_rvalid = 1'b0;
      if (pend && rst_n) begin
        cnt--;
        if (cnt <= 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(pend_addr);
          pend        = 1'b0;
        end
      end
      imem_ack = ($urandom_range(99) < ack_pct);
    end
  end

  // Scoreboard: decode must see an unbroken +4 stream from the last reset/redirect target.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  logic        prev_req;
  logic        prev_ack;
  logic        prev_rst;
  logic [31:0] prev_addr;

  task automatic reload(input logic [31:0] p);
    exp_q.delete();
    gen_pc = p;
  endtask

  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  initial begin
    logic [31:0] e;
    reload(RPC);
    refill();
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_rst = 1'b0;
    prev_addr = 32'h0;
    forever begin
      @(negedge clk); #4;
      if (!rst_n) begin
        reload(RPC);
        refill();
        prev_rst = 1'b0;
        continue;
      end
      if (instr_valid && !stall && !redirect) begin
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e);
        chk("sb_instr", instr, memf(e));
        consumed++;
      end
      if (redirect) reload(redirect_pc);
      refill();
      if (!instr_valid) chk("nop_when_invalid", instr, NOP);
      if (imem_req) chk("addr_aligned", {30'h0, imem_addr[1:0]}, 32'h0);
      if (prev_rst && prev_req && !prev_ack && imem_req) chk("addr_stable", imem_addr, prev_addr);
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      prev_rst  = 1'b1;
    end
  end

  task automatic wait_accept(input string name);
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_ack) begin
        checks++;
        return;
      end
      @(negedge clk);
    end
    checks++;
    failures++;
    $display("FAIL %s: no accepted request within 20 cycles", name);
  endtask

  initial begin
    logic [31:0] tmp;
    int          n;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_addr", imem_addr, RPC);

    // First fetch right after reset release, output two cycles later.
    rst_n = 1'b1; #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, RPC);
    @(negedge clk);
    chk("first_not_yet", instr_valid, 0);
    @(negedge clk);
    chk("first_valid", instr_valid, 1);
    chk("first_instr", instr, 32'hA);
    chk("first_pc", instr_pc, RPC);
    chk("stream_req0", imem_req, 1);

    // Zero-wait streaming.
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("stream_valid", instr_valid, 1);
      chk("stream_pc", instr_pc, RPC + 32'(4 * k));
      chk("stream_req", imem_req, 1);
    end

    // Stall with a response landing: it is parked, issue stops.
    stall = 1'b1; #1;
    chk("stall_req_now", imem_req, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold_pc", instr_pc, RPC + 32'h20);
      chk("stall_hold_valid", instr_valid, 1);
      chk("stall_req", imem_req, 0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("unstall_pc", instr_pc, RPC + 32'h24);
    chk("unstall_instr", instr, memf(RPC + 32'h24));
    chk("unstall_valid", instr_valid, 1);

    // Redirect while waiting; the late response must be dropped.
    delay = 3;
    wait_accept("redir_accept");
    @(negedge clk);
    redirect = 1'b1; redirect_pc = 32'h200; #1;
    chk("redir_req_low", imem_req, 0);
    @(negedge clk);
    redirect = 1'b0;
    chk("redir_valid", instr_valid, 0);
    chk("redir_pc", imem_addr, 32'h200);
    n = 0;
    while (!imem_req && n < 10) begin
      chk("drop_no_stale", instr_valid, 0);
      @(negedge clk);
      n++;
    end
    chk("drop_cycles", n, 2);
    chk("refetch_addr", imem_addr, 32'h200);
    delay = 1;

    // Redirect together with stall while the output holds a live instruction.
    n = 0;
    while (!instr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rs_have_valid", instr_valid, 1);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect = 1'b0;
    chk("rs_valid", instr_valid, 0);
    chk("rs_instr", instr, NOP);
    chk("rs_pc", imem_addr, 32'h300);
    stall = 1'b0;

    // Asynchronous reset in the middle of an outstanding request.
    delay = 3;
    repeat (3) @(negedge clk);
    wait_accept("rst_accept");
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_addr", imem_addr, RPC);
    chk("arst_instr", instr, NOP);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rerst_req", imem_req, 1);
    chk("rerst_addr", imem_addr, RPC);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c % 500 == 0) begin
        ack_pct = $urandom_range(100, 30);
        delay   = $urandom_range(3, 1);
      end
      stall    = ($urandom_range(99) < 30);
      redirect = ($urandom_range(99) < 4);
      tmp      = $urandom();
      tmp[1:0] = 2'b00;
      redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : tmp;
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
    end
    @(negedge clk);
    stall = 1'b0; redirect = 1'b0; ack_pct = 100; delay = 1;
    repeat (10) @(negedge clk);
    checks++;
    if (consumed < 100) begin
      failures++;
      $display("FAIL progress: consumed %0d required at least 100", consumed);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
